// File: rtl/sequenciador_uart_jogo_if.sv
// Byte-transmitter handshake between the status sequencer (master) and the
// serial transmitter (slave).
interface sequenciador_uart_jogo_if;
    logic       tx_partida;
    logic [7:0] tx_dado;
    logic       tx_pronto;

    modport master (output tx_partida, output tx_dado, input tx_pronto);
    modport slave  (input tx_partida, input tx_dado, output tx_pronto);
endinterface

// File: rtl/sequenciador_uart_jogo.sv
// Sends a 7-byte ASCII snapshot of the game status through the UART
// transmitter, with a one-deep request queue and a per-byte watchdog.
//
// state   | meaning
// INICIAL | idle, waiting for a request
// CAPTURA | latch status snapshot, prime first byte
// ENVIA   | pulse tx_partida for the current byte
// ESPERA  | wait for tx_pronto, watchdog running
// PROXIMO | advance byte index or finish
// FIM     | frame done pulse; chain queued request
// ERRO    | transmitter did not answer in time
module sequenciador_uart_jogo #(
    parameter int TIMEOUT = 10000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enviar,
    input  logic [3:0]                      estado,
    input  logic [3:0]                      macro,
    input  logic [3:0]                      micro,
    input  logic [1:0]                      resultado_macro,
    input  logic [1:0]                      resultado_jogo,
    sequenciador_uart_jogo_if.master        tx,
    output logic                            ocupado,
    output logic                            fim_envio,
    output logic                            erro,
    output logic [3:0]                      db_estado
);
    localparam logic [3:0] INICIAL = 4'd0;
    localparam logic [3:0] CAPTURA = 4'd1;
    localparam logic [3:0] ENVIA   = 4'd2;
    localparam logic [3:0] ESPERA  = 4'd3;
    localparam logic [3:0] PROXIMO = 4'd4;
    localparam logic [3:0] FIM     = 4'd5;
    localparam logic [3:0] ERRO    = 4'd14;

    localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    logic [3:0]      estado_fsm;
    logic            pendente;
    logic [2:0]      indice;
    logic [2:0]      indice_prox;
    logic [WD_W-1:0] watchdog;
    logic [7:0]      dado;
    logic [7:0]      byte_prox;
    logic [3:0]      snap_estado;
    logic [3:0]      snap_macro;
    logic [3:0]      snap_micro;
    logic [1:0]      snap_res_macro;
    logic [1:0]      snap_res_jogo;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        hex_ascii = (v <= 4'd9) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    assign indice_prox = indice + 3'd1;

    // Frame byte for the next index, built from the frozen snapshot.
    always_comb begin
        byte_prox = 8'h0A;
        case (indice_prox)
            3'd0:    byte_prox = 8'h23;
            3'd1:    byte_prox = hex_ascii(snap_estado);
            3'd2:    byte_prox = hex_ascii(snap_macro);
            3'd3:    byte_prox = hex_ascii(snap_micro);
            3'd4:    byte_prox = 8'h30 + {6'h00, snap_res_macro};
            3'd5:    byte_prox = 8'h30 + {6'h00, snap_res_jogo};
            default: byte_prox = 8'h0A;
        endcase
    end

    // Sequencer: state, byte index, watchdog, snapshot, output byte, pending request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_fsm     <= INICIAL;
            pendente       <= 1'b0;
            indice         <= 3'd0;
            watchdog       <= '0;
            dado           <= 8'h00;
            snap_estado    <= 4'h0;
            snap_macro     <= 4'h0;
            snap_micro     <= 4'h0;
            snap_res_macro <= 2'd0;
            snap_res_jogo  <= 2'd0;
        end else begin
            case (estado_fsm)
                INICIAL: begin
                    // A request left queued by FIM is served here as well.
                    if (enviar || pendente) begin
                        estado_fsm <= CAPTURA;
                        pendente   <= 1'b0;
                    end
                end
                CAPTURA: begin
                    snap_estado    <= estado;
                    snap_macro     <= macro;
                    snap_micro     <= micro;
                    snap_res_macro <= resultado_macro;
                    snap_res_jogo  <= resultado_jogo;
                    indice         <= 3'd0;
                    watchdog       <= '0;
                    dado           <= 8'h23;
                    estado_fsm     <= ENVIA;
                    if (enviar) pendente <= 1'b1;
                end
                ENVIA: begin
                    estado_fsm <= ESPERA;
                    if (enviar) pendente <= 1'b1;
                end
                ESPERA: begin
                    if (enviar) pendente <= 1'b1;
                    if (tx.tx_pronto) begin
                        estado_fsm <= PROXIMO;
                    end else if (watchdog == WD_MAX) begin
                        estado_fsm <= ERRO;
                        pendente   <= 1'b0;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                PROXIMO: begin
                    watchdog <= '0;
                    if (enviar) pendente <= 1'b1;
                    if (indice == 3'd6) begin
                        estado_fsm <= FIM;
                    end else begin
                        indice     <= indice_prox;
                        dado       <= byte_prox;
                        estado_fsm <= ENVIA;
                    end
                end
                FIM: begin
                    if (pendente) begin
                        estado_fsm <= CAPTURA;
                        pendente   <= 1'b0;
                    end else begin
                        estado_fsm <= INICIAL;
                        if (enviar) pendente <= 1'b1;
                    end
                end
                ERRO: begin
                    if (enviar) estado_fsm <= CAPTURA;
                end
                default: estado_fsm <= INICIAL;
            endcase
        end
    end

    assign tx.tx_partida = (estado_fsm == ENVIA);
    assign tx.tx_dado    = dado;
    assign ocupado       = (estado_fsm != INICIAL) && (estado_fsm != ERRO);
    assign fim_envio     = (estado_fsm == FIM);
    assign erro          = (estado_fsm == ERRO);
    assign db_estado     = estado_fsm;
endmodule

// File: tb/tb_sequenciador_uart_jogo.sv
// Directed/randomized bench for the UART status sequencer with a
// transmitter model and an arithmetic frame reference.
module tb_sequenciador_uart_jogo;
    typedef struct {
        logic [3:0] e;
        logic [3:0] ma;
        logic [3:0] mi;
        logic [1:0] rm;
        logic [1:0] rj;
    } snap_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enviar = 1'b0;
    logic [3:0] estado = 4'h0;
    logic [3:0] macro = 4'h0;
    logic [3:0] micro = 4'h0;
    logic [1:0] resultado_macro = 2'd0;
    logic [1:0] resultado_jogo = 2'd0;
    logic       ocupado;
    logic       fim_envio;
    logic       erro;
    logic [3:0] db_estado;
    logic       pronto_drv = 1'b0;

    sequenciador_uart_jogo_if tx();
    assign tx.tx_pronto = pronto_drv;

    sequenciador_uart_jogo #(.TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .enviar(enviar),
        .estado(estado),
        .macro(macro),
        .micro(micro),
        .resultado_macro(resultado_macro),
        .resultado_jogo(resultado_jogo),
        .tx(tx),
        .ocupado(ocupado),
        .fim_envio(fim_envio),
        .erro(erro),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model controls (written only by the main block).
    int   lat = 1;
    logic force_pronto = 1'b0;
    logic spur_envia = 1'b0;

    // Observations (written only by the model).
    logic [7:0] sent_q[$];
    int         partida_cyc[$];
    int         fim_n = 0;
    int         fim_cyc = 0;
    int         unstable = 0;
    int         cd = 0;
    logic [7:0] cur_byte = 8'h00;

    // Transmitter model: answers each start 'lat' cycles later (lat<0: never).
    always begin
        @(posedge clock);
        #1;
        pronto_drv = 1'b0;
        if (reset) begin
            cd = 0;
        end else begin
            if (tx.tx_partida) begin
                sent_q.push_back(tx.tx_dado);
                partida_cyc.push_back(cyc);
                cur_byte = tx.tx_dado;
                cd = lat;
                if (spur_envia) pronto_drv = 1'b1;
            end else if (cd > 0) begin
                if (tx.tx_dado !== cur_byte) unstable++;
                cd--;
                if (cd == 0) pronto_drv = 1'b1;
            end
            if (fim_envio) begin
                fim_n++;
                fim_cyc = cyc;
            end
            if (force_pronto) pronto_drv = 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexa(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    // Reference frame: '#', three hex digits, two result digits, newline.
    function automatic logic [7:0] exp_byte(input snap_t s, input int i);
        case (i)
            0:       return 8'd35;
            1:       return hexa(int'(s.e));
            2:       return hexa(int'(s.ma));
            3:       return hexa(int'(s.mi));
            4:       return 8'(48 + int'(s.rm));
            5:       return 8'(48 + int'(s.rj));
            default: return 8'd10;
        endcase
    endfunction

    task automatic rnd_snap(output snap_t s);
        s.e  = 4'($urandom_range(0, 15));
        s.ma = 4'($urandom_range(0, 15));
        s.mi = 4'($urandom_range(0, 15));
        s.rm = 2'($urandom_range(0, 3));
        s.rj = 2'($urandom_range(0, 3));
    endtask

    task automatic apply(input snap_t s);
        estado = s.e;
        macro = s.ma;
        micro = s.mi;
        resultado_macro = s.rm;
        resultado_jogo = s.rj;
    endtask

    task automatic pulse_enviar();
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
        int n = 0;
        while (db_estado !== code && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(db_estado), 32'(code));
    endtask

    task automatic wait_partidas(input int target, input int budget, input string tag);
        int n = 0;
        while (sent_q.size() < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, sent_q.size(), target);
    endtask

    task automatic check_frame(input int base, input snap_t s, input string tag);
        chk({tag, "_len"}, (sent_q.size() >= base + 7) ? 1 : 0, 1);
        for (int i = 0; i < 7; i++) begin
            if (base + i < sent_q.size())
                chk($sformatf("%s_b%0d", tag, i), 32'(sent_q[base + i]), 32'(exp_byte(s, i)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_partida"}, 32'(tx.tx_partida), 0);
        chk({tag, "_dado"}, 32'(tx.tx_dado), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
        chk({tag, "_fim"}, 32'(fim_envio), 0);
        chk({tag, "_erro"}, 32'(erro), 0);
        chk({tag, "_db"}, 32'(db_estado), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        snap_t s, s2;
        int base, base2, f0, n, p, cap, n0;

        // Reset state
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_db", 32'(db_estado), 0);

        // Directed frame, transmitter answers after 5 cycles
        s.e = 4'h4; s.ma = 4'hA; s.mi = 4'h3; s.rm = 2'd2; s.rj = 2'd0;
        apply(s);
        lat = 5;
        base = sent_q.size();
        f0 = fim_n;
        pulse_enviar();
        chk("t1_captura", 32'(db_estado), 1);
        chk("t1_ocupado", 32'(ocupado), 1);
        @(negedge clock);
        chk("t1_partida", 32'(tx.tx_partida), 1);
        chk("t1_dado0", 32'(tx.tx_dado), 32'h23);
        wait_state(4'd0, 300, "t1_idle");
        chk("t1_npartida", sent_q.size() - base, 7);
        chk("t1_nfim", fim_n - f0, 1);
        chk("t1_ocupado_end", 32'(ocupado), 0);
        check_frame(base, s, "t1");

        // Minimum-latency frame timing
        rnd_snap(s);
        apply(s);
        lat = 1;
        base = sent_q.size();
        pulse_enviar();
        cap = cyc;
        wait_state(4'd0, 100, "t2_idle");
        chk("t2_frame_len", fim_cyc - cap, 22);
        for (int i = 0; i < 6; i++)
            if (base + i + 1 < partida_cyc.size())
                chk($sformatf("t2_spacing%0d", i), partida_cyc[base + i + 1] - partida_cyc[base + i], 3);
        check_frame(base, s, "t2");

        // Snapshot is frozen after capture
        rnd_snap(s);
        apply(s);
        lat = $urandom_range(1, 4);
        base = sent_q.size();
        pulse_enviar();
        @(negedge clock);
        estado = 4'hF;
        macro = 4'h0;
        micro = ~s.mi;
        resultado_macro = ~s.rm;
        resultado_jogo = ~s.rj;
        wait_state(4'd0, 200, "t3_idle");
        check_frame(base, s, "t3");

        // Three requests during byte 2 collapse into one chained frame
        rnd_snap(s);
        apply(s);
        lat = 6;
        base = sent_q.size();
        f0 = fim_n;
        pulse_enviar();
        wait_partidas(base + 3, 100, "t4_byte2");
        pulse_enviar();
        @(negedge clock);
        pulse_enviar();
        @(negedge clock);
        pulse_enviar();
        rnd_snap(s2);
        apply(s2);
        n = 0;
        while (fim_n == f0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("t4_fim1_state", 32'(db_estado), 5);
        @(negedge clock);
        chk("t4_chain_captura", 32'(db_estado), 1);
        wait_state(4'd0, 300, "t4_idle");
        chk("t4_npartida", sent_q.size() - base, 14);
        chk("t4_nfim", fim_n - f0, 2);
        check_frame(base, s, "t4a");
        check_frame(base + 7, s2, "t4b");

        // Watchdog expiry with silent transmitter
        rnd_snap(s);
        apply(s);
        lat = -1;
        base = sent_q.size();
        pulse_enviar();
        wait_partidas(base + 1, 20, "t5_start");
        p = (partida_cyc.size() > base) ? partida_cyc[base] : 0;
        @(negedge clock);
        pulse_enviar();
        wait_state(4'd14, 60, "t5_erro_state");
        chk("t5_wd_cycles", cyc - p, 17);
        chk("t5_erro", 32'(erro), 1);
        chk("t5_ocupado", 32'(ocupado), 0);
        repeat (5) @(negedge clock);
        chk("t5_stays_erro", 32'(db_estado), 14);
        lat = 1;
        rnd_snap(s2);
        apply(s2);
        base2 = sent_q.size();
        f0 = fim_n;
        pulse_enviar();
        chk("t5_restart", 32'(db_estado), 1);
        chk("t5_erro_drop", 32'(erro), 0);
        wait_state(4'd0, 100, "t5_idle");
        check_frame(base2, s2, "t5");
        chk("t5_nfim", fim_n - f0, 1);
        repeat (30) @(negedge clock);
        chk("t5_no_extra", sent_q.size() - base2, 7);
        chk("t5_db_idle", 32'(db_estado), 0);

        // Spurious tx_pronto in idle and in ENVIA; answer on last watchdog cycle
        n0 = sent_q.size();
        force_pronto = 1'b1;
        repeat (2) @(negedge clock);
        force_pronto = 1'b0;
        repeat (2) @(negedge clock);
        chk("t6_spur_idle", 32'(db_estado), 0);
        chk("t6_spur_nopartida", sent_q.size(), n0);
        rnd_snap(s);
        apply(s);
        lat = 16;
        spur_envia = 1'b1;
        base = sent_q.size();
        f0 = fim_n;
        pulse_enviar();
        wait_state(4'd0, 400, "t6_idle");
        spur_envia = 1'b0;
        chk("t6_nfim", fim_n - f0, 1);
        check_frame(base, s, "t6");
        chk("t6_stable", unstable, 0);

        // Asynchronous reset during byte 4
        rnd_snap(s);
        apply(s);
        lat = 5;
        base = sent_q.size();
        pulse_enviar();
        wait_partidas(base + 5, 100, "t7_byte4");
        @(negedge clock);
        chk("t7_in_espera", 32'(db_estado), 3);
        #2 reset = 1'b1;
        #1 check_reset_outputs("t7_async");
        @(negedge clock);
        reset = 1'b0;
        n0 = sent_q.size();
        repeat (30) @(negedge clock);
        chk("t7_no_resume", sent_q.size(), n0);
        chk("t7_db_idle", 32'(db_estado), 0);
        rnd_snap(s);
        apply(s);
        lat = 2;
        base = sent_q.size();
        pulse_enviar();
        wait_state(4'd0, 100, "t7_idle");
        chk("t7_npartida", sent_q.size() - base, 7);
        check_frame(base, s, "t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
